// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory responder and its word array.
package cpu_mem_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned MAX_LATENCY = 15;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage : cpu_mem_pkg

// File: rtl/mem_word_ram.sv
// Single-port word array with synchronous write and registered read.
// The read register only updates on an enabled load and holds otherwise.
module mem_word_ram
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [WORD_W-1:0]    wdata_i,
  output logic [WORD_W-1:0]    rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Enabled store writes the array; enabled load captures the addressed word.
  // NOTE: the array and its read register have no reset; contents must survive
  // a reset and clearing them would stop the array mapping to RAM macros.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule : mem_word_ram

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU MEM-stage data port. Accepts one
// load/store at a time, performs the array access LATENCY-1 edges after
// acceptance and pulses ack_o for one cycle in the following RESP state.
module data_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned LATENCY   = 3,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              stall_o
);

  localparam int unsigned            IDX_HI   = ADDR_BITS + 1;
  localparam logic [CNT_W-1:0]       CNT_INIT = CNT_W'(LATENCY - 1);

  // Reject latencies the 4-bit counter cannot express.
  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be in 1..15");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [IDX_HI:0]     addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                zero_q, zero_d;   // 1: rdata_o reads as zero

  logic                access;
  logic                acc_we;
  logic [IDX_HI:0]     acc_addr;
  logic [WORD_W-1:0]   acc_wdata;
  logic                acc_misal;
  logic                ram_en;
  logic [WORD_W-1:0]   ram_rdata;

  // Address bits above the word index are ignored, so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i[31:IDX_HI+1];

  // Next-state, latch capture and access strobe for the request FSM.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    zero_d    = zero_q;
    access    = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i[IDX_HI:0];
          wdata_d = wdata_i;
          cnt_d   = CNT_INIT;
          if (LATENCY == 1) begin
            // No wait states: access on the acceptance edge itself.
            state_d   = RESP;
            access    = 1'b1;
            acc_we    = we_i;
            acc_addr  = addr_i[IDX_HI:0];
            acc_wdata = wdata_i;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          access  = 1'b1;
        end
      end
      RESP: begin
        // Any req_i seen here is ignored; a held request restarts from IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    acc_misal = |acc_addr[1:0];

    if (access) begin
      err_d = acc_misal;
      if (acc_misal) begin
        zero_d = 1'b1;
      end else if (!acc_we) begin
        zero_d = 1'b0;
      end
    end
  end

  // Array access only on the edge entering RESP, never while reset aborts it.
  assign ram_en = access & ~acc_misal & ~rst_i;

  // State registers with synchronous reset; latched request fields need none.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  // Request copies captured at acceptance; authoritative for the whole transaction.
  always_ff @(posedge clk_i) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  mem_word_ram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk_i   (clk_i),
    .en_i    (ram_en),
    .we_i    (acc_we),
    .addr_i  (acc_addr[IDX_HI:2]),
    .wdata_i (acc_wdata),
    .rdata_o (ram_rdata)
  );

  assign ack_o   = (state_q == RESP);
  assign err_o   = ack_o & err_q;
  assign rdata_o = zero_q ? '0 : ram_rdata;
  assign stall_o = req_i & ~ack_o;

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance at LATENCY=3, one at
// LATENCY=1, sharing clock and reset. Expected values are hand-computed.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk = ~clk;

  logic        req3 = 1'b0, we3 = 1'b0;
  logic [31:0] addr3 = '0, wdata3 = '0;
  logic [31:0] rdata3;
  logic        ack3, err3, stall3;

  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [31:0] rdata1;
  logic        ack1, err1, stall1;

  int checks   = 0;
  int failures = 0;

  data_mem_responder #(.LATENCY(3), .ADDR_BITS(8)) dut3 (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .req_i   (req3),
    .we_i    (we3),
    .addr_i  (addr3),
    .wdata_i (wdata3),
    .rdata_o (rdata3),
    .ack_o   (ack3),
    .err_o   (err3),
    .stall_o (stall3)
  );

  data_mem_responder #(.LATENCY(1), .ADDR_BITS(8)) dut1 (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .req_i   (req1),
    .we_i    (we1),
    .addr_i  (addr1),
    .wdata_i (wdata1),
    .rdata_o (rdata1),
    .ack_o   (ack1),
    .err_o   (err1),
    .stall_o (stall1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One LATENCY=3 transaction. Entered and left at posedge+1 with req3 low.
  // Inputs are scrambled after acceptance to show the latched copies are used.
  task automatic txn3(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input logic exp_err);
    int n = 0;
    int stalls = 0;
    req3 = 1'b1; we3 = we; addr3 = addr; wdata3 = wdata;
    #1;
    if (stall3) stalls++;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (ack3) break;
      if (stall3) stalls++;
      if (n == 1) begin
        we3 = ~we; addr3 = 32'h0000_0044; wdata3 = 32'h5A5A_5A5A;
      end
    end
    check({tag, "_lat"},    n, 3);
    check({tag, "_stalls"}, stalls, 3);
    check({tag, "_ackstall"}, {31'd0, stall3}, 32'd0);
    check({tag, "_err"},    {31'd0, err3}, {31'd0, exp_err});
    check({tag, "_rdata"},  rdata3, exp_rd);
    req3 = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ackdrop"}, {31'd0, ack3}, 32'd0);
  endtask

  // One LATENCY=1 single transaction, same entry/exit convention.
  task automatic txn1(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd);
    req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    @(posedge clk); #1;
    check({tag, "_ack"},   {31'd0, ack1}, 32'd1);
    check({tag, "_rdata"}, rdata1, exp_rd);
    req1 = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ackdrop"}, {31'd0, ack1}, 32'd0);
  endtask

  logic [31:0] b2b_addr [3] = '{32'h0000_0040, 32'h0000_0044, 32'h0000_0040};
  logic [31:0] b2b_data [3] = '{32'h0000_0111, 32'h0000_0222, 32'h0000_0111};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // Idle after reset: nothing pulses, read data is zero.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_ack3",   {31'd0, ack3},   32'd0);
      check("idle_err3",   {31'd0, err3},   32'd0);
      check("idle_stall3", {31'd0, stall3}, 32'd0);
      check("idle_rdata3", rdata3,          32'd0);
      check("idle_ack1",   {31'd0, ack1},   32'd0);
    end

    txn3("st_beef",   1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
    txn3("ld_beef",   1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0);
    txn3("ld_misal",  1'b0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1);
    txn3("ld_beef2",  1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0);
    txn3("st_alias",  1'b1, 32'h0000_0400, 32'h0000_1234, 32'hDEAD_BEEF, 1'b0);
    txn3("ld_alias",  1'b0, 32'h0000_0000, 32'h0,         32'h0000_1234, 1'b0);
    txn3("st_pre",    1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'h0000_1234, 1'b0);

    // Reset one cycle into a store: it must be discarded with no ack.
    req3 = 1'b1; we3 = 1'b1; addr3 = 32'h0000_0020; wdata3 = 32'hAAAA_5555;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0; req3 = 1'b0;
    check("rst_rdata", rdata3, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst_noack", {31'd0, ack3}, 32'd0);
    end
    txn3("ld_post_rst", 1'b0, 32'h0000_0020, 32'h0, 32'h0BAD_F00D, 1'b0);

    // LATENCY=1: preload, then back-to-back loads with req1 held high.
    txn1("l1_st0", 1'b1, 32'h0000_0040, 32'h0000_0111, 32'd0);
    txn1("l1_st1", 1'b1, 32'h0000_0044, 32'h0000_0222, 32'd0);
    txn1("l1_st2", 1'b1, 32'h0000_0080, 32'h0000_0333, 32'd0);
    req1 = 1'b1; we1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      addr1 = b2b_addr[k];
      #1;
      check("b2b_stall_idle", {31'd0, stall1}, 32'd1);
      @(posedge clk); #1;
      check("b2b_ack",        {31'd0, ack1},   32'd1);
      check("b2b_rdata",      rdata1,          b2b_data[k]);
      check("b2b_stall_ack",  {31'd0, stall1}, 32'd0);
      addr1 = 32'h0000_0080;
      @(posedge clk); #1;
      check("b2b_gap",        {31'd0, ack1},   32'd0);
    end
    req1 = 1'b0;
    #1;
    check("b2b_stall_off", {31'd0, stall1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_data_mem_responder
